// File: rtl/jk_pkg.sv
// Shared mode encoding and JK operation codes for the JK-cell based counter.
package jk_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_JK   = 2'b11
  } mode_e;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

endpackage

// File: rtl/jk_cell.sv
// Single-bit JK flip-flop with cell enable and asynchronous active-high reset.
module jk_cell
  import jk_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (ce) begin
      unique case ({j, k})
        JK_HOLD: q <= q;
        JK_RST:  q <= 1'b0;
        JK_SET:  q <= 1'b1;
        JK_TGL:  q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_mode_counter.sv
// WIDTH-bit hold/up/down/JK register built from jk_cell flops.
// Define JK_CTR_SAT_EN to make up/down counting saturate instead of wrapping.
module jk_mode_counter
  import jk_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MODULUS   = 256,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] RST_VEC = WIDTH'(RESET_VAL);

  mode_e            mode_t;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] jk_val;
  logic [WIDTH-1:0] cell_j;
  logic [WIDTH-1:0] cell_k;
  logic             upd;
  logic             jk_pass;
  logic             wrap_d;
  logic             wrap_q;

  assign mode_t = mode_e'(mode);
  // Per-bit JK result: hold, clear, set or toggle.
  assign jk_val = (j & ~q) | (~k & q);

  always_comb begin
    nxt     = q;
    upd     = 1'b0;
    jk_pass = 1'b0;
    wrap_d  = 1'b0;
    if (load) begin
      upd = 1'b1;
      nxt = ({1'b0, d} >= MOD_EXT) ? MAX_VAL : d;
    end else if (en) begin
      unique case (mode_t)
        MODE_UP: begin
          upd = 1'b1;
          if (q == MAX_VAL) begin
            wrap_d = 1'b1;
`ifdef JK_CTR_SAT_EN
            nxt = q;
`else
            nxt = '0;
`endif
          end else begin
            nxt = q + 1'b1;
          end
        end
        MODE_DOWN: begin
          upd = 1'b1;
          if (q == '0) begin
            wrap_d = 1'b1;
`ifdef JK_CTR_SAT_EN
            nxt = q;
`else
            nxt = MAX_VAL;
`endif
          end else begin
            nxt = q - 1'b1;
          end
        end
        MODE_JK: begin
          upd = 1'b1;
          if ({1'b0, jk_val} >= MOD_EXT) begin
            nxt = MAX_VAL;
          end else begin
            nxt     = jk_val;
            jk_pass = 1'b1;
          end
        end
        default: begin
          nxt = q;
        end
      endcase
    end
  end

  // Cells see raw J/K in unclamped JK mode, otherwise J/K that steer them to nxt.
  always_comb begin
    cell_j = nxt & ~q;
    cell_k = ~nxt & q;
    if (jk_pass) begin
      cell_j = j;
      cell_k = k;
    end
  end

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
    jk_cell #(
      .RST_VAL(RST_VEC[i])
    ) u_cell (
      .clk(clk),
      .rst(rst),
      .ce (upd),
      .j  (cell_j[i]),
      .k  (cell_k[i]),
      .q  (q[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign qn   = ~q;
  assign wrap = wrap_q;
  assign tc   = ((mode_t == MODE_UP) && (q == MAX_VAL)) ||
                ((mode_t == MODE_DOWN) && (q == '0));

endmodule

// File: tb/tb_jk_mode_counter.sv
// Directed self-checking bench for jk_mode_counter (MODULUS=10 and MODULUS=16 instances).
module tb_jk_mode_counter;
  import jk_pkg::*;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic       load;
  logic [3:0] d;
  logic [3:0] j;
  logic [3:0] k;
  logic [3:0] q10, qn10, q16, qn16;
  logic       tc10, wrap10, tc16, wrap16;

  int n_tests = 0;
  int n_fail  = 0;

  jk_mode_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .d(d), .j(j), .k(k),
    .q(q10), .qn(qn10), .tc(tc10), .wrap(wrap10)
  );

  jk_mode_counter #(.WIDTH(4), .MODULUS(16), .RESET_VAL(0)) dut16 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .d(d), .j(j), .k(k),
    .q(q16), .qn(qn16), .tc(tc16), .wrap(wrap16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [3:0] val);
    load = 1'b1;
    d    = val;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; mode = MODE_HOLD; load = 1'b0; d = '0; j = '0; k = '0;
    tick();
    tick();
    n_tests++;
    if (q10 !== 4'd0) begin n_fail++; $display("FAIL reset_q: got %0d want 0", q10); end
    n_tests++;
    if (qn10 !== 4'hF) begin n_fail++; $display("FAIL reset_qn: got %h want f", qn10); end
    n_tests++;
    if (wrap10 !== 1'b0) begin n_fail++; $display("FAIL reset_wrap: got %b want 0", wrap10); end
    n_tests++;
    if (tc10 !== 1'b0) begin n_fail++; $display("FAIL reset_tc: got %b want 0", tc10); end
    rst = 1'b0;
  endtask

  task automatic test_up();
    logic [3:0] eq;
    en = 1'b1; mode = MODE_UP;
    #1;
    n_tests++;
    if (q10 !== 4'd0 || tc10 !== 1'b0) begin
      n_fail++; $display("FAIL up_start: got q=%0d tc=%b want q=0 tc=0", q10, tc10);
    end
    for (int i = 1; i <= 12; i++) begin
      tick();
      eq = 4'(i % 10);
      n_tests++;
      if (q10 !== eq) begin n_fail++; $display("FAIL up_q[%0d]: got %0d want %0d", i, q10, eq); end
      n_tests++;
      if (wrap10 !== (i == 10)) begin
        n_fail++; $display("FAIL up_wrap[%0d]: got %b want %b", i, wrap10, (i == 10));
      end
      n_tests++;
      if (tc10 !== (eq == 4'd9)) begin
        n_fail++; $display("FAIL up_tc[%0d]: got %b want %b", i, tc10, (eq == 4'd9));
      end
    end
    n_tests++;
    if (qn10 !== 4'b1101) begin n_fail++; $display("FAIL up_qn: got %b want 1101", qn10); end
  endtask

  task automatic test_down();
    logic [3:0] exp_q [9] = '{4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd9, 4'd8};
    mode = MODE_DOWN;
    do_load(4'd7);
    n_tests++;
    if (q10 !== 4'd7 || wrap10 !== 1'b0) begin
      n_fail++; $display("FAIL down_load: got q=%0d wrap=%b want q=7 wrap=0", q10, wrap10);
    end
    for (int i = 0; i < 9; i++) begin
      tick();
      n_tests++;
      if (q10 !== exp_q[i]) begin
        n_fail++; $display("FAIL down_q[%0d]: got %0d want %0d", i, q10, exp_q[i]);
      end
      n_tests++;
      if (wrap10 !== (i == 7)) begin
        n_fail++; $display("FAIL down_wrap[%0d]: got %b want %b", i, wrap10, (i == 7));
      end
      n_tests++;
      if (tc10 !== (exp_q[i] == 4'd0)) begin
        n_fail++; $display("FAIL down_tc[%0d]: got %b want %b", i, tc10, (exp_q[i] == 4'd0));
      end
    end
    do_load(4'd12);
    n_tests++;
    if (q10 !== 4'd9) begin n_fail++; $display("FAIL load_clamp12: got %0d want 9", q10); end
    n_tests++;
    if (q16 !== 4'd12) begin n_fail++; $display("FAIL load16_12: got %0d want 12", q16); end
    do_load(4'd15);
    n_tests++;
    if (q10 !== 4'd9) begin n_fail++; $display("FAIL load_clamp15: got %0d want 9", q10); end
  endtask

  task automatic test_jk();
    en = 1'b1; mode = MODE_HOLD;
    do_load(4'b0101);
    mode = MODE_JK; j = 4'b1100; k = 4'b0110;
    tick();
    n_tests++;
    if (q16 !== 4'b1001) begin n_fail++; $display("FAIL jk16_q: got %b want 1001", q16); end
    n_tests++;
    if (q10 !== 4'b1001) begin n_fail++; $display("FAIL jk10_q: got %b want 1001", q10); end
    n_tests++;
    if (wrap16 !== 1'b0 || wrap10 !== 1'b0) begin
      n_fail++; $display("FAIL jk_wrap: got %b/%b want 0/0", wrap16, wrap10);
    end
    // 0101 with set on bits 3 and 1 gives 1111: out of range for MODULUS=10.
    mode = MODE_HOLD;
    do_load(4'b0101);
    mode = MODE_JK; j = 4'b1010; k = 4'b0000;
    tick();
    n_tests++;
    if (q10 !== 4'd9) begin n_fail++; $display("FAIL jk_clamp10: got %0d want 9", q10); end
    n_tests++;
    if (q16 !== 4'hF) begin n_fail++; $display("FAIL jk16_set: got %h want f", q16); end
    n_tests++;
    if (tc10 !== 1'b0) begin n_fail++; $display("FAIL jk_tc: got %b want 0", tc10); end
    j = '0; k = '0;
  endtask

  task automatic test_async_reset();
    en = 1'b1; mode = MODE_HOLD;
    do_load(4'd4);
    mode = MODE_UP;
    tick();
    n_tests++;
    if (q10 !== 4'd5) begin n_fail++; $display("FAIL ar_pre: got %0d want 5", q10); end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (q10 !== 4'd0) begin n_fail++; $display("FAIL ar_q_async: got %0d want 0", q10); end
    rst = 1'b0;
    mode = MODE_HOLD;
    do_load(4'd9);
    mode = MODE_UP;
    tick();
    n_tests++;
    if (wrap10 !== 1'b1) begin n_fail++; $display("FAIL ar_wrap_pre: got %b want 1", wrap10); end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (wrap10 !== 1'b0) begin n_fail++; $display("FAIL ar_wrap_async: got %b want 0", wrap10); end
    tick();
    n_tests++;
    if (q10 !== 4'd0) begin n_fail++; $display("FAIL ar_hold: got %0d want 0", q10); end
    rst = 1'b0;
    tick();
    n_tests++;
    if (q10 !== 4'd1) begin n_fail++; $display("FAIL ar_resume: got %0d want 1", q10); end
  endtask

  task automatic test_enable();
    en = 1'b0; mode = MODE_UP;
    do_load(4'd3);
    n_tests++;
    if (q10 !== 4'd3) begin n_fail++; $display("FAIL en_load: got %0d want 3", q10); end
    tick();
    n_tests++;
    if (q10 !== 4'd3 || wrap10 !== 1'b0) begin
      n_fail++; $display("FAIL en_hold: got q=%0d wrap=%b want q=3 wrap=0", q10, wrap10);
    end
    do_load(4'd9);
    tick();
    n_tests++;
    if (q10 !== 4'd9 || tc10 !== 1'b1) begin
      n_fail++; $display("FAIL en_tc_up: got q=%0d tc=%b want q=9 tc=1", q10, tc10);
    end
    mode = MODE_DOWN;
    #1;
    n_tests++;
    if (tc10 !== 1'b0) begin n_fail++; $display("FAIL en_tc_down: got %b want 0", tc10); end
    tick();
    n_tests++;
    if (q10 !== 4'd9) begin n_fail++; $display("FAIL en_hold_down: got %0d want 9", q10); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_q [4];
    logic       exp_w [4];
`ifdef JK_CTR_SAT_EN
    exp_q = '{4'd9, 4'd9, 4'd9, 4'd9};
    exp_w = '{1'b0, 1'b1, 1'b1, 1'b1};
`else
    exp_q = '{4'd9, 4'd0, 4'd1, 4'd2};
    exp_w = '{1'b0, 1'b1, 1'b0, 1'b0};
`endif
    en = 1'b1; mode = MODE_UP;
    do_load(4'd8);
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++;
      if (q10 !== exp_q[i]) begin
        n_fail++; $display("FAIL b2b_q[%0d]: got %0d want %0d", i, q10, exp_q[i]);
      end
      n_tests++;
      if (wrap10 !== exp_w[i]) begin
        n_fail++; $display("FAIL b2b_wrap[%0d]: got %b want %b", i, wrap10, exp_w[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_up();
    test_down();
    test_jk();
    test_async_reset();
    test_enable();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
